// File: rtl/axi_rd_master.sv
// AXI4 read-channel initiator: one burst command at a time, single AR request, R beats
// streamed straight through to a local consumer, then a one-cycle done/done_err report.
module axi_rd_master #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ASIZE  = $clog2(DATA_W / 8),
   parameter logic [1:0]  ID_VAL = 2'b00
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_len,
   input  logic [1:0]        cmd_burst,
   output logic [1:0]        arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [ASIZE-1:0]  arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              rd_last,
   output logic              done,
   output logic              done_err
);

   typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic [7:0]          arlen_q, arlen_d;
   logic [1:0]          arburst_q, arburst_d;
   logic                arvalid_q, arvalid_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                done_q, done_d;
   logic                done_err_q, done_err_d;

   logic in_data;
   logic last_cnt;
   logic beat;

   assign in_data  = (state_q == StData);
   assign last_cnt = (cnt_q == 8'd0);
   assign beat     = in_data && rvalid && rd_ready;

   always_comb begin
      state_d    = state_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      arburst_d  = arburst_q;
      arvalid_d  = arvalid_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      done_d     = 1'b0;
      done_err_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               if (!cmd_burst[1]) begin
                  araddr_d  = cmd_addr;
                  arlen_d   = cmd_len;
                  arburst_d = cmd_burst;
                  arvalid_d = 1'b1;
                  state_d   = StAddr;
               end else begin
                  // WRAP/reserved: never reaches the bus, reported as an error at once
                  err_d      = 1'b1;
                  done_d     = 1'b1;
                  done_err_d = 1'b1;
                  state_d    = StResp;
               end
            end
         end
         StAddr: begin
            if (arready) begin
               arvalid_d = 1'b0;
               cnt_d     = arlen_q;
               err_d     = 1'b0;
               state_d   = StData;
            end
         end
         StData: begin
            if (beat) begin
               // Burst length is ours, not the slave's: a wrong rlast only flags an error
               err_d = err_q | (rresp != 2'b00) | (rlast != last_cnt);
               cnt_d = cnt_q - 8'd1;
               if (last_cnt) begin
                  done_d     = 1'b1;
                  done_err_d = err_d;
                  state_d    = StResp;
               end
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= StIdle;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arburst_q  <= '0;
         arvalid_q  <= 1'b0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         done_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arburst_q  <= arburst_d;
         arvalid_q  <= arvalid_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         done_q     <= done_d;
         done_err_q <= done_err_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign arid      = ID_VAL;
   assign araddr    = araddr_q;
   assign arlen     = arlen_q;
   assign arsize    = ASIZE'(ASIZE);
   assign arburst   = arburst_q;
   assign arvalid   = arvalid_q;
   assign rready    = in_data & rd_ready;
   assign rd_data   = rdata;
   assign rd_valid  = in_data & rvalid;
   assign rd_last   = in_data & last_cnt;
   assign done      = done_q;
   assign done_err  = done_err_q;

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed bench for axi_rd_master: the bench plays both the AXI slave and the local consumer.
module tb_axi_rd_master;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic [7:0]  cmd_len = '0;
   logic [1:0]  cmd_burst = '0;
   logic [1:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [1:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rlast = 1'b0;
   logic        rvalid = 1'b0;
   logic        rready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic        rd_last;
   logic        done;
   logic        done_err;

   int n_checks = 0;
   int n_fail = 0;

   axi_rd_master dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_burst (cmd_burst),
      .arid      (arid),
      .araddr    (araddr),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rlast     (rlast),
      .rvalid    (rvalid),
      .rready    (rready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_last   (rd_last),
      .done      (done),
      .done_err  (done_err)
   );

   always #5 aclk = ~aclk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] beat_data(input logic [31:0] addr, input int k);
      return {addr[15:0], 8'h5A, 8'(k)};
   endfunction

   // Full transaction from the IDLE negedge to the negedge after done.
   // bad_beat / early_last are 1-based beat numbers (0 = none).
   task automatic run_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int ar_delay, input int bad_beat,
                            input int early_last, input bit use_pat, input bit exp_err);
      logic [6:0] pat;
      logic       rdy;
      int         k;
      int         cyc;
      pat = 7'b1011001;
      check_val("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_burst = burst;
      @(negedge aclk);
      cmd_valid = 1'b0;
      cmd_addr  = 32'hDEAD_BEEF;
      cmd_len   = 8'hEE;
      for (int i = 0; i <= ar_delay; i++) begin
         arready = (i == ar_delay);
         #1;
         check_val("arvalid_held", arvalid, 1);
         check_val("araddr", araddr, addr);
         check_val("arlen", arlen, len);
         check_val("arburst", arburst, burst);
         check_val("arsize", arsize, 2);
         check_val("arid", arid, 0);
         check_val("cmd_ready_busy", cmd_ready, 0);
         @(negedge aclk);
      end
      arready = 1'b0;
      k = 0;
      cyc = 0;
      while (k <= int'(len) && cyc < 600) begin
         rdy      = use_pat ? pat[cyc % 7] : 1'b1;
         rd_ready = rdy;
         rvalid   = 1'b1;
         rdata    = beat_data(addr, k);
         rresp    = (k + 1 == bad_beat) ? 2'b10 : 2'b00;
         rlast    = (k == int'(len)) || (k + 1 == early_last);
         #1;
         check_val("rready", rready, rdy);
         check_val("rd_valid", rd_valid, 1);
         check_val("rd_data", rd_data, beat_data(addr, k));
         check_val("rd_last", rd_last, k == int'(len));
         check_val("arvalid_data", arvalid, 0);
         check_val("done_early", done, 0);
         if (rdy) k++;
         @(negedge aclk);
         cyc++;
      end
      check_val("beat_count", k, int'(len) + 1);
      rvalid   = 1'b0;
      rlast    = 1'b0;
      rresp    = 2'b00;
      rd_ready = 1'b0;
      #1;
      check_val("done", done, 1);
      check_val("done_err", done_err, exp_err);
      check_val("rd_valid_resp", rd_valid, 0);
      @(negedge aclk);
      check_val("done_pulse", done, 0);
      check_val("cmd_ready_after", cmd_ready, 1);
   endtask

   initial begin
      #2;
      check_val("rst_cmd_ready", cmd_ready, 1);
      check_val("rst_arvalid", arvalid, 0);
      check_val("rst_araddr", araddr, 0);
      check_val("rst_arlen", arlen, 0);
      check_val("rst_arburst", arburst, 0);
      check_val("rst_rready", rready, 0);
      check_val("rst_rd_valid", rd_valid, 0);
      check_val("rst_rd_last", rd_last, 0);
      check_val("rst_done", done, 0);
      check_val("rst_done_err", done_err, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);

      // INCR len 3 with AR stall, then back-pressured, then FIXED single beat
      run_burst(32'h100, 8'd3, 2'b01, 2, 0, 0, 1'b0, 1'b0);
      run_burst(32'h100, 8'd3, 2'b01, 0, 0, 0, 1'b1, 1'b0);
      run_burst(32'h340, 8'd0, 2'b00, 1, 0, 0, 1'b0, 1'b0);
      // Error response on beat 2, then early rlast on beat 3
      run_burst(32'h180, 8'd3, 2'b01, 0, 2, 0, 1'b0, 1'b1);
      run_burst(32'h1C0, 8'd3, 2'b01, 0, 0, 3, 1'b0, 1'b1);
      // A clean burst afterwards must not inherit the error flag
      run_burst(32'h400, 8'd2, 2'b01, 0, 0, 0, 1'b1, 1'b0);

      // Unsupported burst type: no AR, immediate error report
      cmd_valid = 1'b1;
      cmd_burst = 2'b10;
      cmd_addr  = 32'h500;
      cmd_len   = 8'd3;
      @(negedge aclk);
      cmd_valid = 1'b0;
      #1;
      check_val("bad_arvalid", arvalid, 0);
      check_val("bad_done", done, 1);
      check_val("bad_done_err", done_err, 1);
      @(negedge aclk);
      check_val("bad_done_pulse", done, 0);
      check_val("bad_arvalid2", arvalid, 0);
      check_val("bad_cmd_ready", cmd_ready, 1);

      // Reset in the middle of beat 2
      cmd_valid = 1'b1;
      cmd_burst = 2'b01;
      cmd_addr  = 32'h200;
      cmd_len   = 8'd3;
      @(negedge aclk);
      cmd_valid = 1'b0;
      arready   = 1'b1;
      @(negedge aclk);
      arready  = 1'b0;
      rvalid   = 1'b1;
      rd_ready = 1'b1;
      rdata    = beat_data(32'h200, 0);
      @(negedge aclk);
      rdata = beat_data(32'h200, 1);
      #1;
      check_val("pre_rst_rready", rready, 1);
      aresetn = 1'b0;
      #1;
      check_val("mid_rst_arvalid", arvalid, 0);
      check_val("mid_rst_rready", rready, 0);
      check_val("mid_rst_done", done, 0);
      check_val("mid_rst_rd_valid", rd_valid, 0);
      rvalid   = 1'b0;
      rd_ready = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      check_val("post_rst_cmd_ready", cmd_ready, 1);
      check_val("post_rst_done", done, 0);
      run_burst(32'h600, 8'd1, 2'b01, 0, 0, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
